// File: rtl/wb_cache_ctrl.sv
// Direct-mapped, write-back, write-allocate cache controller with one word per line.
// Misses first write back a dirty victim, then fill the line, then re-run the compare.
module wb_cache_ctrl #(
  parameter int ADDR_W  = 10,
  parameter int DATA_W  = 20,
  parameter int INDEX_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_req,
  input  logic              cpu_rw,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_ready,
  output logic              cpu_busy,
  output logic              hit,
  output logic              mem_req,
  output logic              mem_rw,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack
);

  localparam int LINES = 2**INDEX_W;
  localparam int TAG_W = ADDR_W - INDEX_W;

  typedef enum logic [1:0] {S_IDLE, S_COMPARE, S_WRITEBACK, S_ALLOCATE} state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic                rw_q, rw_d;
  logic                retry_q, retry_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic                ready_q, ready_d;
  logic                hit_q, hit_d;
  logic [LINES-1:0]    valid_q, dirty_q;
  logic [TAG_W-1:0]    tag_q  [LINES];
  logic [DATA_W-1:0]   data_q [LINES];

  logic [INDEX_W-1:0]  idx;
  logic [TAG_W-1:0]    tag_l;
  logic                lookup_hit;
  logic                wr_hit, wb_done, fill;

  assign idx        = addr_q[INDEX_W-1:0];
  assign tag_l      = addr_q[ADDR_W-1:INDEX_W];
  assign lookup_hit = valid_q[idx] && (tag_q[idx] == tag_l);

  assign cpu_rdata = rdata_q;
  assign cpu_ready = ready_q;
  assign hit       = hit_q;
  assign cpu_busy  = (state_q != S_IDLE);

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    rw_d      = rw_q;
    retry_d   = retry_q;
    rdata_d   = rdata_q;
    ready_d   = 1'b0;
    hit_d     = 1'b0;
    wr_hit    = 1'b0;
    wb_done   = 1'b0;
    fill      = 1'b0;
    mem_req   = 1'b0;
    mem_rw    = 1'b0;
    mem_addr  = addr_q;
    mem_wdata = '0;
    case (state_q)
      S_IDLE: begin
        if (cpu_req) begin
          addr_d  = cpu_addr;
          wdata_d = cpu_wdata;
          rw_d    = cpu_rw;
          retry_d = 1'b0;
          state_d = S_COMPARE;
        end
      end
      S_COMPARE: begin
        if (lookup_hit) begin
          ready_d = 1'b1;
          hit_d   = !retry_q;
          if (rw_q) wr_hit  = 1'b1;
          else      rdata_d = data_q[idx];
          state_d = S_IDLE;
        end else begin
          retry_d = 1'b1;
          state_d = (valid_q[idx] && dirty_q[idx]) ? S_WRITEBACK : S_ALLOCATE;
        end
      end
      S_WRITEBACK: begin
        mem_req   = 1'b1;
        mem_rw    = 1'b1;
        mem_addr  = {tag_q[idx], idx};
        mem_wdata = data_q[idx];
        if (mem_ack) begin
          wb_done = 1'b1;
          state_d = S_ALLOCATE;
        end
      end
      S_ALLOCATE: begin
        mem_req = 1'b1;
        if (mem_ack) begin
          fill    = 1'b1;
          state_d = S_COMPARE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      rw_q    <= 1'b0;
      retry_q <= 1'b0;
      rdata_q <= '0;
      ready_q <= 1'b0;
      hit_q   <= 1'b0;
      valid_q <= '0;
      dirty_q <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rw_q    <= rw_d;
      retry_q <= retry_d;
      rdata_q <= rdata_d;
      ready_q <= ready_d;
      hit_q   <= hit_d;
      if (fill) begin
        valid_q[idx] <= 1'b1;
        dirty_q[idx] <= 1'b0;
      end
      if (wb_done) dirty_q[idx] <= 1'b0;
      if (wr_hit)  dirty_q[idx] <= 1'b1;
    end
  end

  // Tag/data storage is unreset; write enables are all gated by a non-IDLE state.
  always_ff @(posedge clk) begin
    if (fill) begin
      data_q[idx] <= mem_rdata;
      tag_q[idx]  <= tag_l;
    end
    if (wr_hit) data_q[idx] <= wdata_q;
  end

endmodule
